countdown_timer_ctl: RTL and testbench

COUNTDOWN_TIMER_CTL -- requirements
Module: countdown_timer_ctl

---
 rtl/timer_pkg.sv | 31 +++
 rtl/tick_gen.sv | 36 +++
 rtl/countdown_timer_ctl.sv | 184 ++++++++++++++++++
 tb/tb_countdown_timer_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg : shared types/constants for countdown_timer_ctl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_MAX = 59;

  // Binary 0..99 to a {tens, units} BCD byte.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = bcd_digit_t'(v / 7'd10);
    units = bcd_digit_t'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen : free-running modulo-TICK_DIV counter with enable and sync clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int c_cnt_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
    end
  end

  // Raw terminal count; the consumer qualifies it with its own enable.
  assign o_tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/countdown_timer_ctl.sv
// ----------------------------------------------------------------------------
// countdown_timer_ctl : MM:SS up/down timer with preset edit, pause and expiry
// Optional blink output enabled by macro COUNTDOWN_TIMER_BLINK_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module countdown_timer_ctl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int MIN_MAX  = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setting,
  input  logic        mode_up,
  input  logic        min_inc,
  input  logic        sec_inc,
  input  logic        start_stop,
  input  logic        pause_resume,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        paused,
  output logic        done,
`ifdef COUNTDOWN_TIMER_BLINK_EN
  output logic        blank,
`endif
  output logic        done_pulse
);

  localparam logic [6:0] c_min_max = 7'(MIN_MAX);
  localparam logic [5:0] c_sec_max = 6'(SEC_MAX);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_pmin, w_pmin_nxt, r_cmin, w_cmin_nxt, w_step_min, w_up_min;
  logic [5:0] r_psec, w_psec_nxt, r_csec, w_csec_nxt, w_step_sec, w_up_sec;
  logic       r_mode, w_mode_nxt;
  logic       r_done_pulse, w_done_pulse_nxt;
  logic       w_tick_en, w_tick_clr, w_tick_term, w_step_end, w_preset_nz;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tick_en),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick_term)
  );

  // Counter only advances on cycles where no higher-priority input wins.
  assign w_tick_en   = (r_state == RUN) && !setting && !start_stop && !pause_resume;
  assign w_preset_nz = (r_pmin != 7'd0) || (r_psec != 6'd0);
  assign w_up_min    = w_preset_nz ? r_pmin : c_min_max;
  assign w_up_sec    = w_preset_nz ? r_psec : c_sec_max;

  always_comb begin
    w_step_min = r_cmin;
    w_step_sec = r_csec;
    if (r_mode) begin
      if (r_csec == c_sec_max) begin
        w_step_sec = 6'd0;
        w_step_min = r_cmin + 7'd1;
      end else begin
        w_step_sec = r_csec + 6'd1;
      end
      w_step_end = (w_step_min == w_up_min) && (w_step_sec == w_up_sec);
    end else begin
      if (r_csec == 6'd0) begin
        w_step_sec = c_sec_max;
        w_step_min = r_cmin - 7'd1;
      end else begin
        w_step_sec = r_csec - 6'd1;
      end
      w_step_end = (w_step_min == 7'd0) && (w_step_sec == 6'd0);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pmin_nxt       = r_pmin;
    w_psec_nxt       = r_psec;
    w_cmin_nxt       = r_cmin;
    w_csec_nxt       = r_csec;
    w_mode_nxt       = r_mode;
    w_tick_clr       = 1'b0;
    w_done_pulse_nxt = 1'b0;
    if (setting) begin
      w_state_nxt = IDLE;
      if (r_state == IDLE) begin
        if (min_inc) w_pmin_nxt = (r_pmin >= c_min_max) ? 7'd0 : r_pmin + 7'd1;
        if (sec_inc) w_psec_nxt = (r_psec >= c_sec_max) ? 6'd0 : r_psec + 6'd1;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_stop && (mode_up || w_preset_nz)) begin
            w_state_nxt = RUN;
            w_mode_nxt  = mode_up;
            w_tick_clr  = 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            w_state_nxt = IDLE;
          end else if (pause_resume) begin
            w_state_nxt = PAUSE;
          end else if (w_tick_term) begin
            w_cmin_nxt = w_step_min;
            w_csec_nxt = w_step_sec;
            if (w_step_end) begin
              w_state_nxt      = DONE;
              w_done_pulse_nxt = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start_stop)        w_state_nxt = IDLE;
          else if (pause_resume) w_state_nxt = RUN;
        end
        DONE: begin
          if (start_stop) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    // Display tracks the (possibly just edited) preset whenever idle.
    if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
      w_cmin_nxt = mode_up ? 7'd0 : w_pmin_nxt;
      w_csec_nxt = mode_up ? 6'd0 : w_psec_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pmin       <= 7'd0;
      r_psec       <= 6'd0;
      r_cmin       <= 7'd0;
      r_csec       <= 6'd0;
      r_mode       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pmin       <= w_pmin_nxt;
      r_psec       <= w_psec_nxt;
      r_cmin       <= w_cmin_nxt;
      r_csec       <= w_csec_nxt;
      r_mode       <= w_mode_nxt;
      r_done_pulse <= w_done_pulse_nxt;
    end
  end

  assign time_bcd   = {to_bcd(r_cmin), to_bcd({1'b0, r_csec})};
  assign running    = (r_state == RUN);
  assign paused     = (r_state == PAUSE);
  assign done       = (r_state == DONE);
  assign done_pulse = r_done_pulse;

`ifdef COUNTDOWN_TIMER_BLINK_EN
  localparam int c_half   = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
  localparam int c_bcnt_w = (c_half > 2) ? $clog2(c_half) : 1;
  localparam logic [c_bcnt_w-1:0] c_blast = c_bcnt_w'(c_half - 1);
  localparam logic [c_bcnt_w-1:0] c_bone  = c_bcnt_w'(1);

  logic [c_bcnt_w-1:0] r_bcnt;
  logic                r_blank;

  always_ff @(posedge clk) begin
    if (rst || (r_state != DONE)) begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end else if (r_bcnt == c_blast) begin
      r_bcnt  <= '0;
      r_blank <= ~r_blank;
    end else begin
      r_bcnt  <= r_bcnt + c_bone;
    end
  end

  assign blank = r_blank;
`endif

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ctl.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer_ctl : scoreboard bench, TICK_DIV=4, MIN_MAX=59
// Rev 1.1
// ----------------------------------------------------------------------------
`default_nettype none

module tb_countdown_timer_ctl;

    logic        clk = 1'b0;
    logic        rst, setting, mode_up, min_inc, sec_inc, start_stop, pause_resume;
    logic [15:0] time_bcd;
    logic        running, paused, done, done_pulse;
`ifdef COUNTDOWN_TIMER_BLINK_EN
    logic        blank;
`endif

    localparam logic [3:0] F_RUN = 4'b1000, F_PAU = 4'b0100, F_DONE = 4'b0010, F_DP = 4'b0001;
    localparam int P_MI = 0, P_SI = 1, P_SS = 2, P_PR = 3;

    countdown_timer_ctl #(.TICK_DIV(4), .MIN_MAX(59)) dut (
        .clk          (clk),
        .rst          (rst),
        .setting      (setting),
        .mode_up      (mode_up),
        .min_inc      (min_inc),
        .sec_inc      (sec_inc),
        .start_stop   (start_stop),
        .pause_resume (pause_resume),
        .time_bcd     (time_bcd),
        .running      (running),
        .paused       (paused),
        .done         (done),
`ifdef COUNTDOWN_TIMER_BLINK_EN
        .blank        (blank),
`endif
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] t;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic expect_out(input string name, input logic [15:0] t, input logic [3:0] f);
        exp_t e;
        e.name = name;
        e.t    = t;
        e.f    = f;
        q.push_back(e);
    endtask

    // Monitor: every expectation queued during a cycle is checked on its falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            if (time_bcd !== m_e.t || {running, paused, done, done_pulse} !== m_e.f) begin
                n_err++;
                $display("FAIL %s: got time=%h flags(r,p,d,dp)=%b, want time=%h flags=%b",
                         m_e.name, time_bcd, {running, paused, done, done_pulse}, m_e.t, m_e.f);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which, input int n);
        repeat (n) begin
            case (which)
                P_MI:    min_inc      = 1'b1;
                P_SI:    sec_inc      = 1'b1;
                P_SS:    start_stop   = 1'b1;
                default: pause_resume = 1'b1;
            endcase
            step(1);
            min_inc = 1'b0; sec_inc = 1'b0; start_stop = 1'b0; pause_resume = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; setting = 1'b0; mode_up = 1'b0;
        min_inc = 1'b0; sec_inc = 1'b0; start_stop = 1'b0; pause_resume = 1'b0;
        step(2);
        rst = 1'b0;
        expect_out("reset", 16'h0000, 4'b0000);

        // Preset editing and second-field wrap
        setting = 1'b1;
        step(1);
        pulse(P_SI, 3);
        pulse(P_MI, 1);
        expect_out("preset_0103", 16'h0103, 4'b0000);
        pulse(P_SI, 57);
        expect_out("sec_wrap_00", 16'h0100, 4'b0000);
        pulse(P_SI, 62);
        expect_out("sec_62_reads_02", 16'h0102, 4'b0000);
        pulse(P_SI, 58);
        expect_out("preset_0100", 16'h0100, 4'b0000);

        // Countdown 01:00 to expiry
        setting = 1'b0;
        step(1);
        expect_out("idle_down", 16'h0100, 4'b0000);
        pulse(P_SS, 1);
        expect_out("down_start", 16'h0100, F_RUN);
        step(3);
        expect_out("before_tick", 16'h0100, F_RUN);
        step(1);
        expect_out("first_tick", 16'h0059, F_RUN);
        step(235);
        expect_out("last_sec", 16'h0001, F_RUN);
        step(1);
        expect_out("expire", 16'h0000, F_DONE | F_DP);
        n_checks++;
        if (done_pulse !== 1'b1 || time_bcd !== 16'h0000) begin
            n_err++;
            $display("FAIL expire_direct: got time=%h dp=%b, want time=0000 dp=1",
                     time_bcd, done_pulse);
        end
        step(1);
        expect_out("done_pulse_once", 16'h0000, F_DONE);
        step(8);
        expect_out("done_hold", 16'h0000, F_DONE);
        pulse(P_PR, 1);
        expect_out("done_ignores_pr", 16'h0000, F_DONE);
        pulse(P_SS, 1);
        expect_out("done_to_idle", 16'h0100, 4'b0000);

        // Count-up to preset 00:05 (minute wraps 59 -> 0 on the way)
        setting = 1'b1;
        pulse(P_MI, 59);
        pulse(P_SI, 5);
        expect_out("min_wrap_0005", 16'h0005, 4'b0000);
        setting = 1'b0;
        mode_up = 1'b1;
        step(1);
        expect_out("idle_up_zero", 16'h0000, 4'b0000);
        pulse(P_SS, 1);
        expect_out("up_start", 16'h0000, F_RUN);
        step(19);
        expect_out("up_0004", 16'h0004, F_RUN);
        step(1);
        expect_out("up_done", 16'h0005, F_DONE | F_DP);
        step(12);
        expect_out("up_hold", 16'h0005, F_DONE);
        n_checks++;
        if (time_bcd !== 16'h0005 || done !== 1'b1 || running !== 1'b0) begin
            n_err++;
            $display("FAIL up_hold_direct: got time=%h done=%b run=%b, want time=0005 done=1 run=0",
                     time_bcd, done, running);
        end
        pulse(P_SS, 1);
        expect_out("up_to_idle", 16'h0000, 4'b0000);

        // Pause two cycles into a tick period, then resume
        mode_up = 1'b0;
        step(1);
        expect_out("idle_0005", 16'h0005, 4'b0000);
        pulse(P_SS, 1);
        expect_out("run_0005", 16'h0005, F_RUN);
        step(2);
        pulse(P_PR, 1);
        expect_out("paused", 16'h0005, F_PAU);
        step(10);
        expect_out("pause_frozen", 16'h0005, F_PAU);
        n_checks++;
        if (time_bcd !== 16'h0005 || paused !== 1'b1) begin
            n_err++;
            $display("FAIL pause_frozen_direct: got time=%h paused=%b, want time=0005 paused=1",
                     time_bcd, paused);
        end
        pulse(P_PR, 1);
        expect_out("resumed", 16'h0005, F_RUN);
        step(1);
        expect_out("resume_plus1", 16'h0005, F_RUN);
        step(1);
        expect_out("resume_plus2", 16'h0004, F_RUN);

        // Priority: start_stop beats pause_resume; setting leaves PAUSE
        start_stop = 1'b1; pause_resume = 1'b1;
        step(1);
        start_stop = 1'b0; pause_resume = 1'b0;
        expect_out("ss_beats_pr", 16'h0005, 4'b0000);
        pulse(P_SS, 1);
        expect_out("restart", 16'h0005, F_RUN);
        pulse(P_PR, 1);
        expect_out("pause_again", 16'h0005, F_PAU);
        setting = 1'b1;
        step(1);
        expect_out("setting_from_pause", 16'h0005, 4'b0000);
        setting = 1'b0;
        step(1);

        // Reset one cycle before expiry
        pulse(P_SS, 1);
        expect_out("run_for_rst", 16'h0005, F_RUN);
        step(19);
        expect_out("pre_expiry", 16'h0001, F_RUN);
        rst = 1'b1;
        step(1);
        expect_out("rst_in_run", 16'h0000, 4'b0000);
        n_checks++;
        if (done_pulse !== 1'b0 || running !== 1'b0 || done !== 1'b0 || time_bcd !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_direct: got time=%h r=%b d=%b dp=%b, want all zero",
                     time_bcd, running, done, done_pulse);
        end
        rst = 1'b0;
        step(1);
        expect_out("after_rst", 16'h0000, 4'b0000);
        pulse(P_SS, 1);
        expect_out("zero_start_ignored", 16'h0000, 4'b0000);

        step(2);
        if (n_err != 0) begin
            $display("FAIL summary: got %0d errors, want 0", n_err);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
